// File: rtl/cp0_timer_unit_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, exception codes
// and the exception-return address helper.
package cp0_timer_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_W   = 5;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD      = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] addr;
    addr = bd ? (pc - 32'd4) : pc;
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Free-running Count, Compare and the sticky timer-pending flag.
// Writes arriving here are already qualified by the caller.
module cp0_timer
  import cp0_timer_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        wr_count, wr_compare;

  assign wr_count   = wr_en_i && (wr_addr_i == CP0_COUNT);
  assign wr_compare = wr_en_i && (wr_addr_i == CP0_COMPARE);

  always_comb begin
    count_d   = wr_count ? wr_data_i : (count_q + 32'd1);
    compare_d = wr_compare ? wr_data_i : compare_q;
    pend_d    = pend_q;
    // Acknowledging via Compare beats a match seen in the same cycle.
    if (wr_compare) begin
      pend_d = 1'b0;
    end else if (count_q == compare_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_timer_unit.sv
// CP0 subset: SR/Cause/EPC/PrID with interrupt and exception entry, eret, and an
// optional Count/Compare timer feeding the top interrupt line.
module cp0_timer_unit
  import cp0_timer_unit_pkg::*;
#(
  parameter int          NUM_HWINT = 5,
  parameter logic [31:0] PRID_VAL  = 32'h1937_3189,
  parameter bit          TIMER_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 eret,
  output logic                 req,
  output logic [31:0]          epc,
  output logic [31:0]          rd_data,
  output logic                 timer_irq
);

  localparam int W = NUM_HWINT + 1;

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_irq_q;

  logic [31:0] count, compare;
  logic        timer_pend;
  logic [W-1:0] irq_vec;
  logic        int_req, exc_req, req_int, wr_ok;
  logic [31:0] epc_calc;

  assign irq_vec = {timer_pend, hwint};
  assign int_req = (|(irq_vec & sr_q[SR_IM_LSB +: W])) && sr_q[SR_IE] && !sr_q[SR_EXL];
  assign exc_req = (exc_code != 5'd0) && !sr_q[SR_EXL];
  // Gate with reset so a held reset never presents a request.
  assign req_int = !reset && (int_req || exc_req);
  assign wr_ok   = wr_en && !req_int;
  assign epc_calc = calc_epc(pc, bd);

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk       (clk),
        .reset_i   (reset),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .count_o   (count),
        .compare_o (compare),
        .pend_o    (timer_pend)
      );
    end else begin : g_no_timer
      assign count      = '0;
      assign compare    = '0;
      assign timer_pend = 1'b0;
    end
  endgenerate

  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;

    if (wr_ok && (wr_addr == CP0_SR)) sr_d = wr_data;
    if (wr_ok && (wr_addr == CP0_EPC)) epc_d = {wr_data[31:2], 2'b00};
    if (eret) sr_d[SR_EXL] = 1'b0;

    cause_d[CAUSE_IP_LSB +: W] = irq_vec;

    if (req_int) begin
      sr_d[SR_EXL]     = 1'b1;
      cause_d[CAUSE_BD] = bd;
      cause_d[CAUSE_EXC_LSB +: CAUSE_EXC_W] = int_req ? EXC_INT : exc_code;
      epc_d            = epc_calc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      timer_irq_q <= timer_pend;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_COUNT:   rd_data = count;
      CP0_COMPARE: rd_data = compare;
      CP0_SR:      rd_data = sr_q;
      CP0_CAUSE:   rd_data = cause_q;
      CP0_EPC:     rd_data = epc_q;
      CP0_PRID:    rd_data = PRID_VAL;
      default:     rd_data = '0;
    endcase
  end

  assign req       = req_int;
  assign epc       = reset ? 32'd0 : (req_int ? epc_calc : epc_q);
  assign timer_irq = timer_irq_q;

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Scoreboard bench for cp0_timer_unit: the driver pushes expected outputs from a
// behavioural CP0 model; an independent monitor pops and compares each cycle.
module tb_cp0_timer_unit;

  localparam int NH = 5;
  localparam logic [31:0] PRID = 32'h1937_3189;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rd_addr = '0, wr_addr = '0, exc_code = '0;
  logic          wr_en = 1'b0, bd = 1'b0, eret = 1'b0;
  logic [31:0]   wr_data = '0, pc = '0;
  logic [NH-1:0] hwint = '0;
  logic          req, timer_irq;
  logic [31:0]   epc, rd_data;

  always #5 clk = ~clk;

  cp0_timer_unit #(.NUM_HWINT(NH), .PRID_VAL(PRID), .TIMER_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_data(wr_data), .pc(pc), .bd(bd), .exc_code(exc_code), .hwint(hwint),
    .eret(eret), .req(req), .epc(epc), .rd_data(rd_data), .timer_irq(timer_irq)
  );

  typedef struct {
    logic        req;
    logic [31:0] epc;
    logic [31:0] rd;
    logic        tirq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Architectural state of the reference CP0.
  logic [31:0] m_count, m_compare, m_sr, m_cause, m_epc;
  logic        m_pend, m_tirq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("req", {31'd0, req}, {31'd0, mon_e.req});
        check("epc", epc, mon_e.epc);
        check("rd_data", rd_data, mon_e.rd);
        check("timer_irq", {31'd0, timer_irq}, {31'd0, mon_e.tirq});
      end
    end
  end

  task automatic model_clear();
    m_count = 0; m_compare = 0; m_sr = 0; m_cause = 0; m_epc = 0;
    m_pend = 0; m_tirq = 0;
  endtask

  task automatic step(input logic rst, input logic [4:0] ra, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pcv,
                      input logic bdv, input logic [4:0] ec, input logic [NH-1:0] hw,
                      input logic er);
    logic [31:0] irq, im, calc, ipmask;
    logic        ireq, ereq, r, wok;
    exp_t        e;
    @(negedge clk);
    reset = rst; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    pc = pcv; bd = bdv; exc_code = ec; hwint = hw; eret = er;
    if (rst) begin
      model_clear();
      e.req = 1'b0;
      e.epc = 32'd0;
      e.rd  = (ra == 5'd15) ? PRID : 32'd0;
      e.tirq = 1'b0;
      sb.push_back(e);
    end else begin
      ipmask = (32'd1 << (NH + 1)) - 32'd1;
      irq  = ({31'd0, m_pend} << NH) | {{(32-NH){1'b0}}, hw};
      im   = (m_sr >> 10) & ipmask;
      ireq = ((irq & im) != 0) && m_sr[0] && !m_sr[1];
      ereq = (ec != 0) && !m_sr[1];
      r    = ireq || ereq;
      calc = (bdv ? pcv - 32'd4 : pcv) & 32'hFFFF_FFFC;
      case (ra)
        5'd9:    e.rd = m_count;
        5'd11:   e.rd = m_compare;
        5'd12:   e.rd = m_sr;
        5'd13:   e.rd = m_cause;
        5'd14:   e.rd = m_epc;
        5'd15:   e.rd = PRID;
        default: e.rd = 32'd0;
      endcase
      e.req  = r;
      e.epc  = r ? calc : m_epc;
      e.tirq = m_tirq;
      sb.push_back(e);

      wok    = we && !r;
      m_tirq = m_pend;
      if (wok && wa == 5'd11) m_pend = 1'b0;
      else if (m_count == m_compare) m_pend = 1'b1;
      if (wok && wa == 5'd11) m_compare = wd;
      m_count = (wok && wa == 5'd9) ? wd : m_count + 32'd1;
      if (wok && wa == 5'd12) m_sr = wd;
      if (er) m_sr[1] = 1'b0;
      if (r) m_sr[1] = 1'b1;
      m_cause = (m_cause & ~(ipmask << 10)) | (irq << 10);
      if (r) begin
        m_cause[31]  = bdv;
        m_cause[6:2] = ireq ? 5'd0 : ec;
      end
      if (wok && wa == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
      if (r) m_epc = calc;
    end
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    step(1'b0, ra, 1'b1, wa, wd, 32'h0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  task automatic idle(input int n, input logic [4:0] ra, input logic [NH-1:0] hw);
    for (int i = 0; i < n; i++) step(1'b0, ra, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0);
  endtask

  task automatic do_eret(input logic [4:0] ra);
    step(1'b0, ra, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, '0, 1'b1);
  endtask

  logic [4:0]    r_ra, r_wa, r_ec;
  logic          r_we, r_bd, r_er;
  logic [31:0]   r_wd, r_pc;
  logic [NH-1:0] r_hw;
  logic [4:0]    ec_tab [5];
  logic [4:0]    ra_tab [8];
  int            drain;

  initial begin
    ec_tab = '{5'd4, 5'd5, 5'd10, 5'd12, 5'd4};
    ra_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};
    model_clear();

    step(1'b1, 5'd15, 1'b0, 5'd0, 0, 0, 0, 5'd0, '0, 0);
    step(1'b1, 5'd9, 1'b1, 5'd12, 32'hFFFF_FFFF, 0, 0, 5'd12, '1, 0);
    step(1'b1, 5'd12, 1'b0, 5'd0, 0, 32'h100, 1, 5'd4, '1, 0);

    // Hardware interrupt entry
    wr(5'd12, 32'h0000_0401, 5'd12);
    step(0, 5'd13, 0, 5'd0, 0, 32'h2000, 0, 5'd0, 5'b00001, 0);
    step(0, 5'd13, 0, 5'd0, 0, 32'h2004, 0, 5'd0, 5'b00000, 0);
    idle(1, 5'd12, '0);
    do_eret(5'd12);

    // Exception in a delay slot
    step(0, 5'd14, 0, 5'd0, 0, 32'h3010, 1, 5'd12, '0, 0);
    idle(1, 5'd13, '0);
    idle(1, 5'd14, '0);
    do_eret(5'd12);

    // Request suppresses a concurrent SR write
    step(0, 5'd12, 1, 5'd12, 32'h0, 32'h4000, 0, 5'd4, '0, 0);
    idle(1, 5'd12, '0);
    do_eret(5'd12);

    // Timer match
    wr(5'd11, 32'd5, 5'd11);
    wr(5'd9, 32'd0, 5'd9);
    wr(5'd12, 32'h0000_8001, 5'd9);
    idle(8, 5'd13, '0);
    wr(5'd11, 32'h0000_1000, 5'd13);
    idle(2, 5'd13, '0);
    do_eret(5'd12);

    // EXL masks interrupts until eret
    wr(5'd12, 32'h0000_0401, 5'd12);
    idle(3, 5'd12, 5'b00001);
    step(0, 5'd12, 0, 5'd0, 0, 0, 0, 5'd0, 5'b00001, 1);
    idle(1, 5'd13, 5'b00001);
    do_eret(5'd12);

    // Count wrap and match at zero
    wr(5'd12, 32'h0, 5'd12);
    wr(5'd11, 32'h0, 5'd11);
    wr(5'd9, 32'hFFFF_FFFF, 5'd9);
    idle(4, 5'd9, '0);
    idle(1, 5'd13, '0);

    // EPC low bits, unmapped register
    wr(5'd14, 32'h0000_1237, 5'd14);
    idle(1, 5'd14, '0);
    wr(5'd3, 32'hDEAD_BEEF, 5'd3);
    idle(1, 5'd3, '0);

    for (int i = 0; i < 400; i++) begin
      r_ra = ra_tab[$urandom_range(0, 7)];
      r_we = ($urandom_range(0, 3) == 0);
      r_wa = ra_tab[$urandom_range(0, 7)];
      r_wd = $urandom;
      if (r_wa == 5'd12) r_wd = r_wd & 32'h0000_FC03;
      if (r_wa == 5'd11 && $urandom_range(0, 1) == 1) r_wd = m_count + $urandom_range(1, 6);
      r_pc = $urandom;
      r_bd = $urandom_range(0, 1);
      r_ec = ($urandom_range(0, 9) == 0) ? ec_tab[$urandom_range(0, 4)] : 5'd0;
      r_hw = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
      r_er = !r_we && ($urandom_range(0, 5) == 0);
      step((i >= 200 && i < 202), r_ra, r_we, r_wa, r_wd, r_pc, r_bd, r_ec, r_hw, r_er);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    #5;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_timer_unit.md
CP0_TIMER_UNIT -- requirements
Module: cp0_timer_unit

Interface
REQ-001 Parameter NUM_HWINT, default 5, number of external hardware interrupt lines; legal range 1..7.
REQ-002 Parameter PRID_VAL, default 32'h1937_3189, constant returned by the PrID register.
REQ-003 Parameter TIMER_EN, default 1; when 0 the Count/Compare logic is absent, timer_pend is constant 0 and reads of Count/Compare return 0.
REQ-004 Port clk  input  1  system clock, rising-edge active.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port rd_addr  input  5  CP0 register number to read (mfc0).
REQ-007 Port wr_addr  input  5  CP0 register number to write (mtc0).
REQ-008 Port wr_en  input  1  mtc0 write strobe.
REQ-009 Port wr_data  input  32  mtc0 write data.
REQ-010 Port pc  input  32  PC of the instruction in the commit stage.
REQ-011 Port bd  input  1  commit-stage instruction is in a branch delay slot.
REQ-012 Port exc_code  input  5  exception code; 0 means no exception.
REQ-013 Port hwint  input  NUM_HWINT  level-sensitive external interrupts.
REQ-014 Port eret  input  1  eret at commit.
REQ-015 Port req  output  1  take interrupt/exception this cycle (combinational).
REQ-016 Port epc  output  32  exception return address (combinational).
REQ-017 Port rd_data  output  32  read data (combinational).
REQ-018 Port timer_irq  output  1  registered copy of timer_pend.

Function
REQ-019 Registers, by number: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PrID (read-only); any other number reads 0, and writes to it are ignored.
REQ-020 Interrupt vector irq_vec = {timer_pend, hwint}, width W = NUM_HWINT+1; mask IM = SR[10 +: W]; EXL = SR[1]; IE = SR[0].
REQ-021 Interrupt request int_req = |(irq_vec & IM) & IE & !EXL; exception request exc_req = (exc_code != 0) & !EXL; req = int_req | exc_req.
REQ-022 Interrupt has priority over exception: on req, Cause[6:2] <= 0 if int_req, else exc_code.
REQ-023 On req: SR[1] <= 1, Cause[31] <= bd, EPC <= (bd ? pc-4 : pc) with bits [1:0] forced to 0.
REQ-024 epc = that same computed value while req=1, else the EPC register.
REQ-025 Cause[10 +: W] <= irq_vec every cycle, regardless of mask or EXL.
REQ-026 mtc0 (wr_en=1) is suppressed in any cycle with req=1.
REQ-027 SR write loads all 32 bits; EPC write loads wr_data[31:2], with bits [1:0] reading 0.
REQ-028 eret clears SR[1]; if req is also 1 in that cycle, req wins and SR[1]=1.
REQ-029 Count increments by 1 every cycle modulo 2^32 (wrapping FFFF_FFFF -> 0); a Count write loads wr_data instead of incrementing.
REQ-030 timer_pend is sticky: it sets at the edge where Count == Compare (pre-update values) and clears only on a Compare write.
REQ-031 A Compare write takes priority over the set condition in the same cycle.
REQ-032 Reads are combinational from current register state; no write-through bypass.

Reset
REQ-033 reset clears Count, Compare, SR, Cause, EPC, timer_pend and timer_irq to 0 immediately.
REQ-034 While reset is asserted: req=0 and epc=0; rd_data returns PRID_VAL for register 15 and 0 for all others.
REQ-035 Reset mid-operation discards any pending request or write.

Structure
REQ-036 A shared package holds the register-number constants (9, 11-15), the SR/Cause bit-position constants and the ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-037 Count/Compare/timer_pend form one natural sub-module, cp0_timer, instantiated only when TIMER_EN=1.

Verification
REQ-038 Scenario 1: SR=0x0000_0401, hwint[0]=1 -> req=1 the same cycle; next cycle Cause[6:2]=0, SR[1]=1.
REQ-039 Scenario 2: exc_code=12, bd=1, pc=0x3010 -> epc=0x300C; Cause[31]=1, Cause[6:2]=12.
REQ-040 Scenario 3: Compare=5, Count=0 written, SR IM bit 15 and IE set -> timer_pend rises after the edge where Count==5, req follows; a Compare write clears it.
REQ-041 Scenario 4: req=1 together with mtc0 SR=0 -> SR keeps EXL=1 and the write is dropped.
REQ-042 Scenario 5: Count=0xFFFF_FFFF -> 0 on the next edge; Compare=0 -> timer_pend sets.
REQ-043 Scenario 6: SR[1]=1 with hwint asserted -> req=0; after eret, req=1 the following cycle.
